// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified memory port between fetch and load/store,
// data-first with a fetch starvation guard, blocking out-of-range/misaligned accesses.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  output logic              if_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_rd_ctrl,
  input  logic [1:0]        d_wr_ctrl,
  input  logic [31:0]       d_wdata,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_data,
  output logic              d_rsp_err,
  output logic [ADDR_W-1:0] m_addr,
  output logic [2:0]        m_rd_ctrl,
  output logic [1:0]        m_wr_ctrl,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);
  typedef enum logic [1:0] {G_NONE, G_IF, G_D} grant_t;
  grant_t      r_grant;
  logic [3:0]  r_starve;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;
  logic        w_if_win, w_if_g, w_d_g, w_if_err, w_d_err, w_rd_none, w_err;
  logic [31:0] w_rsp_data;
  assign w_if_win  = if_req_valid && (!d_req_valid || r_starve == 4'(STARVE_MAX));
  // grants are masked during reset so the memory port stays idle
  assign w_if_g    = rst_n && w_if_win;
  assign w_d_g     = rst_n && d_req_valid && !w_if_win;
  assign if_req_ready = w_if_g;
  assign d_req_ready  = w_d_g;
  assign w_if_err  = (|if_addr[ADDR_W-1:14]) || (|if_addr[1:0]);
  assign w_d_err   = |d_addr[ADDR_W-1:14];
  assign w_rd_none = d_rd_ctrl == 3'b000 || d_rd_ctrl > 3'b101;
  assign w_err     = w_if_g ? w_if_err : w_d_err;
  assign m_addr    = w_if_g ? if_addr : w_d_g ? d_addr : '0;
  assign m_rd_ctrl = w_if_g && !w_if_err ? 3'b101 : w_d_g && !w_d_err ? d_rd_ctrl : 3'b000;
  assign m_wr_ctrl = w_d_g && !w_d_err ? d_wr_ctrl : 2'b00;
  assign m_wdata   = w_d_g ? d_wdata : '0;
  assign w_rsp_data = w_err || (w_d_g && ((|d_wr_ctrl) || w_rd_none)) ? '0 : m_rdata;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant    <= G_NONE;
      r_starve   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_grant    <= w_if_g ? G_IF : w_d_g ? G_D : G_NONE;
      r_rsp_data <= w_rsp_data;
      r_rsp_err  <= (w_if_g || w_d_g) && w_err;
      r_starve   <= !if_req_valid || w_if_g ? '0 :
                    r_starve == 4'(STARVE_MAX) ? r_starve : r_starve + 4'd1;
    end
  end
  assign if_rsp_valid = r_grant == G_IF;
  assign d_rsp_valid  = r_grant == G_D;
  assign if_rsp_data  = if_rsp_valid ? r_rsp_data : '0;
  assign d_rsp_data   = d_rsp_valid ? r_rsp_data : '0;
  assign if_rsp_err   = if_rsp_valid && r_rsp_err;
  assign d_rsp_err    = d_rsp_valid && r_rsp_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a byte-array memory model and a per-cycle reference checker.
module tb_mem_port_arbiter;
  localparam int STARVE_MAX = 4;
  logic        clk = 0;
  logic        rst_n, ifv, dv;
  logic [31:0] ia, da, wd;
  logic [2:0]  rc;
  logic [1:0]  wc;
  logic        if_req_ready, if_rsp_valid, if_rsp_err, d_req_ready, d_rsp_valid, d_rsp_err;
  logic [31:0] if_rsp_data, d_rsp_data, m_addr, m_wdata, m_rdata;
  logic [2:0]  m_rd_ctrl;
  logic [1:0]  m_wr_ctrl;
  logic [7:0]  mem [16384];
  logic [7:0]  ref_mem [16384];
  int          n_chk = 0, n_fail = 0;
  logic        armed = 0;
  logic        s_ir, s_dr;
  logic [2:0]  s_mrd;
  logic [1:0]  s_mwr;
  int          sc = 0;
  logic        p_if = 0, p_d = 0, p_err = 0;
  logic [31:0] p_data = 0;

  mem_port_arbiter #(.ADDR_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(ifv), .if_req_ready(if_req_ready), .if_addr(ia),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(dv), .d_req_ready(d_req_ready), .d_addr(da),
    .d_rd_ctrl(rc), .d_wr_ctrl(wc), .d_wdata(wd),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .m_addr(m_addr), .m_rd_ctrl(m_rd_ctrl), .m_wr_ctrl(m_wr_ctrl),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ldv(input logic [2:0] c, input logic [31:0] b);
    case (c)
      3'b001:  return {{24{b[7]}}, b[7:0]};
      3'b010:  return {24'h0, b[7:0]};
      3'b011:  return {{16{b[15]}}, b[15:0]};
      3'b100:  return {16'h0, b[15:0]};
      3'b101:  return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rload(input logic [2:0] c, input int a);
    return ldv(c, {ref_mem[(a+3)&16383], ref_mem[(a+2)&16383], ref_mem[(a+1)&16383], ref_mem[a&16383]});
  endfunction

  logic [13:0] ma;
  assign ma = m_addr[13:0];
  assign m_rdata = ldv(m_rd_ctrl, {mem[ma+14'd3], mem[ma+14'd2], mem[ma+14'd1], mem[ma]});

  always @(posedge clk) begin
    if (m_wr_ctrl != 2'b00) mem[ma] <= m_wdata[7:0];
    if (m_wr_ctrl[1]) mem[ma+14'd1] <= m_wdata[15:8];
    if (m_wr_ctrl == 2'b11) begin
      mem[ma+14'd2] <= m_wdata[23:16];
      mem[ma+14'd3] <= m_wdata[31:24];
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // reference: grants from the arbitration rules, responses from a mirror byte memory
  always @(negedge clk) begin
    logic eg_if, eg_d, e_ierr, e_derr;
    int a;
    eg_if  = rst_n && ifv && (!dv || sc == STARVE_MAX);
    eg_d   = rst_n && dv && !eg_if;
    e_ierr = (ia >> 14) != 0 || ia[1:0] != 2'b00;
    e_derr = (da >> 14) != 0;
    if (armed) begin
      chk("if_req_ready", {31'h0, if_req_ready}, {31'h0, eg_if});
      chk("d_req_ready", {31'h0, d_req_ready}, {31'h0, eg_d});
      chk("m_addr", m_addr, eg_if ? ia : eg_d ? da : 32'h0);
      chk("m_rd_ctrl", {29'h0, m_rd_ctrl}, {29'h0, eg_if && !e_ierr ? 3'b101 : eg_d && !e_derr ? rc : 3'b000});
      chk("m_wr_ctrl", {30'h0, m_wr_ctrl}, {30'h0, eg_d && !e_derr ? wc : 2'b00});
      chk("m_wdata", m_wdata, eg_d ? wd : 32'h0);
      chk("if_rsp_valid", {31'h0, if_rsp_valid}, {31'h0, p_if});
      chk("if_rsp_data", if_rsp_data, p_if ? p_data : 32'h0);
      chk("if_rsp_err", {31'h0, if_rsp_err}, {31'h0, p_if && p_err});
      chk("d_rsp_valid", {31'h0, d_rsp_valid}, {31'h0, p_d});
      chk("d_rsp_data", d_rsp_data, p_d ? p_data : 32'h0);
      chk("d_rsp_err", {31'h0, d_rsp_err}, {31'h0, p_d && p_err});
    end
    if (!rst_n) begin
      sc = 0; p_if = 0; p_d = 0; p_err = 0; p_data = 0;
    end else begin
      p_if   = eg_if;
      p_d    = eg_d;
      p_err  = eg_if ? e_ierr : eg_d && e_derr;
      a      = eg_if ? int'(ia[13:0]) : int'(da[13:0]);
      p_data = p_err || !(eg_if || eg_d) ? 32'h0 : eg_if ? rload(3'b101, a) : wc != 2'b00 ? 32'h0 : rload(rc, a);
      if (eg_d && !e_derr && wc != 2'b00) begin
        ref_mem[a] = wd[7:0];
        if (wc[1]) ref_mem[(a+1)&16383] = wd[15:8];
        if (wc == 2'b11) begin
          ref_mem[(a+2)&16383] = wd[23:16];
          ref_mem[(a+3)&16383] = wd[31:24];
        end
      end
      sc = !ifv || eg_if ? 0 : sc < STARVE_MAX ? sc + 1 : sc;
    end
  end

  task automatic cyc(input logic rn, input logic iv, input logic [31:0] iad, input logic v,
                     input logic [31:0] ad, input logic [2:0] r, input logic [1:0] w, input logic [31:0] d);
    rst_n = rn; ifv = iv; ia = iad; dv = v; da = ad; rc = r; wc = w; wd = d;
    #1;
    s_ir = if_req_ready; s_dr = d_req_ready; s_mrd = m_rd_ctrl; s_mwr = m_wr_ctrl;
    @(posedge clk);
    #1;
  endtask

  int exp_sc [6] = '{1, 2, 3, 4, 0, 1};

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = 8'h0;
      ref_mem[i] = 8'h0;
    end
    mem[16] = 8'h93; mem[17] = 8'h00; mem[18] = 8'h50; mem[19] = 8'h00;
    ref_mem[16] = 8'h93; ref_mem[17] = 8'h00; ref_mem[18] = 8'h50; ref_mem[19] = 8'h00;
    rst_n = 0; ifv = 0; dv = 0; ia = 0; da = 0; rc = 0; wc = 0; wd = 0;
    repeat (3) @(posedge clk);
    #1 armed = 1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_if_rsp_valid", {31'h0, if_rsp_valid}, 0);
    chk("idle_d_rsp_valid", {31'h0, d_rsp_valid}, 0);
    chk("idle_m_rd_ctrl", {29'h0, s_mrd}, 0);
    cyc(1, 1, 32'h10, 0, 0, 0, 0, 0);
    chk("fetch_ready", {31'h0, s_ir}, 1);
    chk("fetch_m_rd", {29'h0, s_mrd}, 5);
    chk("fetch_rsp_valid", {31'h0, if_rsp_valid}, 1);
    chk("fetch_rsp_data", if_rsp_data, 32'h00500093);
    chk("fetch_rsp_err", {31'h0, if_rsp_err}, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 32'h20, 1, 32'h200, 3'b101, 2'b00, 0);
      chk("starve_if_grant", {31'h0, s_ir}, {31'h0, i == 4});
      chk("starve_d_grant", {31'h0, s_dr}, {31'h0, i != 4});
      chk("starve_cnt", {28'h0, dut.r_starve}, exp_sc[i]);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 32'h100, 3'b000, 2'b11, 32'hDEADBEEF);
    chk("store_rsp_valid", {31'h0, d_rsp_valid}, 1);
    chk("store_rsp_data", d_rsp_data, 0);
    cyc(1, 0, 0, 1, 32'h101, 3'b010, 2'b00, 0);
    chk("lbu_rsp_data", d_rsp_data, 32'h000000BE);
    cyc(1, 0, 0, 1, 32'h200, 3'b000, 2'b10, 32'h00008081);
    cyc(1, 0, 0, 1, 32'h200, 3'b011, 2'b00, 0);
    chk("lh_rsp_data", d_rsp_data, 32'hFFFF8081);
    cyc(1, 0, 0, 1, 32'h201, 3'b001, 2'b00, 0);
    chk("lb_rsp_data", d_rsp_data, 32'hFFFFFF80);
    cyc(1, 1, 32'h4000, 0, 0, 0, 0, 0);
    chk("ferr_range_m_rd", {29'h0, s_mrd}, 0);
    chk("ferr_range_err", {31'h0, if_rsp_err}, 1);
    chk("ferr_range_data", if_rsp_data, 0);
    cyc(1, 1, 32'h2, 0, 0, 0, 0, 0);
    chk("ferr_align_ready", {31'h0, s_ir}, 1);
    chk("ferr_align_err", {31'h0, if_rsp_err}, 1);
    cyc(1, 0, 0, 1, 32'h8000, 3'b000, 2'b11, 32'h12345678);
    chk("derr_m_wr", {30'h0, s_mwr}, 0);
    chk("derr_err", {31'h0, d_rsp_err}, 1);
    chk("derr_mem0", {mem[3], mem[2], mem[1], mem[0]}, 0);
    cyc(1, 0, 0, 1, 32'h0, 3'b101, 2'b00, 0);
    chk("derr_reload", d_rsp_data, 0);
    cyc(1, 1, 32'h10, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h10, 1, 32'h200, 3'b101, 2'b00, 0);
    chk("rst_ready_masked", {31'h0, s_ir | s_dr}, 0);
    chk("rst_no_if_rsp", {31'h0, if_rsp_valid}, 0);
    chk("rst_no_d_rsp", {31'h0, d_rsp_valid}, 0);
    chk("rst_starve", {28'h0, dut.r_starve}, 0);
    cyc(1, 1, 32'h10, 1, 32'h104, 3'b101, 2'b00, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
